rob_commit_ctrl: RTL and testbench

- In-order retirement controller for the 32-entry, 16-row (two slots per row) reorder buffer.
- Allocates rows to dispatch and owns the head/tail pointers.
- Presents the head row's even/odd slot indices to the completion-status tracker and reads back done/call/ret.
- Generates the per-slot commit strobes that clear the tracker's entries, plus committed call/ret strobes for the return-address stack.

---
 rtl/rob_commit_ctrl_pkg.sv | 23 ++
 rtl/rob_commit_ctrl_if.sv | 41 ++++
 rtl/rob_commit_ctrl_perf_ctr.sv | 19 +
 rtl/rob_commit_ctrl.sv | 135 +++++++++++++
 tb/tb_rob_commit_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/rob_commit_ctrl_pkg.sv
// Shared types and sizing for the reorder-buffer commit controller.
// A slot index is {row, lane}; each row holds an even (lane 0) and odd (lane 1) slot.
package rob_pkg;

    localparam int unsigned ROB_ROWS  = 16;
    localparam int unsigned ROB_SLOTS = 2 * ROB_ROWS;
    localparam int unsigned ROW_W     = $clog2(ROB_ROWS);

    typedef logic [ROW_W-1:0] rob_row_t;
    typedef logic [ROW_W:0]   rob_slot_t;
    typedef logic [ROW_W:0]   rob_cnt_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALF  = 2'd1,
        FLUSH = 2'd2
    } rob_state_t;

    function automatic rob_slot_t slot_of(input rob_row_t row, input logic lane);
        return {row, lane};
    endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch allocation handshake and completion-tracker read-back/clear bundle.
// master = dispatch/tracker side, slave = rob_commit_ctrl.
interface rob_commit_ctrl_if;
    import rob_pkg::*;

    logic      alloc_valid_i;
    logic      alloc_lane1_i;
    logic      alloc_ready_o;
    rob_row_t  alloc_row_o;

    rob_slot_t rob0_status_o;
    rob_slot_t rob1_status_o;
    logic      rob0_done_i;
    logic      rob1_done_i;
    logic      rob0_call_i;
    logic      rob0_ret_i;
    logic      rob1_call_i;
    logic      rob1_ret_i;

    logic      commit0_o;
    logic      commit1_o;

    modport master (
        output alloc_valid_i, alloc_lane1_i,
        output rob0_done_i, rob1_done_i,
        output rob0_call_i, rob0_ret_i, rob1_call_i, rob1_ret_i,
        input  alloc_ready_o, alloc_row_o,
        input  rob0_status_o, rob1_status_o,
        input  commit0_o, commit1_o
    );

    modport slave (
        input  alloc_valid_i, alloc_lane1_i,
        input  rob0_done_i, rob1_done_i,
        input  rob0_call_i, rob0_ret_i, rob1_call_i, rob1_ret_i,
        output alloc_ready_o, alloc_row_o,
        output rob0_status_o, rob1_status_o,
        output commit0_o, commit1_o
    );

endinterface

// File: rtl/rob_commit_ctrl_perf_ctr.sv
// 64-bit retired-instruction counter, advances by 0, 1 or 2 per cycle.
module rob_perf_ctr (
    input  logic        cpu_clk_i,
    input  logic        cpu_rst_i,
    input  logic        inc0_i,
    input  logic        inc1_i,
    output logic [63:0] count_o
);

    // Accumulate both lane strobes; wraps naturally, cleared only by reset.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            count_o <= '0;
        end else begin
            count_o <= count_o + {63'b0, inc0_i} + {63'b0, inc1_i};
        end
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order retirement controller for the two-slot-per-row reorder buffer.
// Owns head/tail/count, grants rows to dispatch, commits the head row in order
// (lane 0 before lane 1) and drives committed call/ret strobes to the RAS.
// Optional: define ROB_COMMIT_PERF_EN to enable the instret_o counter.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned FLUSH_WAIT = 1
) (
    input  logic                  cpu_clk_i,
    input  logic                  cpu_rst_i,
    input  logic                  flush_i,
    rob_commit_ctrl_if.slave      rob_if,
    output logic [1:0]            ras_call_o,
    output logic [1:0]            ras_ret_o,
    output logic                  empty_o,
    output logic [63:0]           instret_o
);

    rob_state_t          state;
    rob_state_t          state_nx;
    rob_row_t            head;
    rob_row_t            tail;
    rob_cnt_t            count;
    logic [ROB_ROWS-1:0] lane1_mask;
    logic [2:0]          wait_cnt;

    logic                lane1_real;
    logic                accept;
    logic                retire;
    logic                commit0;
    logic                commit1;

    assign lane1_real = lane1_mask[head];

    // Space is judged on the registered count only; a same-cycle retire does not help.
    assign rob_if.alloc_ready_o = (count != rob_cnt_t'(ROB_ROWS)) && (state != FLUSH);
    assign rob_if.alloc_row_o   = tail;
    assign accept               = rob_if.alloc_valid_i && rob_if.alloc_ready_o && !flush_i;

    assign rob_if.rob0_status_o = slot_of(head, 1'b0);
    assign rob_if.rob1_status_o = slot_of(head, 1'b1);

    assign empty_o = (count == '0);

    // Head-row commit decision; lane 1 never commits ahead of lane 0 nor for a bubble.
    always_comb begin
        commit0  = 1'b0;
        commit1  = 1'b0;
        retire   = 1'b0;
        state_nx = state;
        if (!flush_i && (count != '0)) begin
            case (state)
                RUN: begin
                    if (rob_if.rob0_done_i) begin
                        commit0 = 1'b1;
                        if (!lane1_real || rob_if.rob1_done_i) begin
                            commit1 = lane1_real && rob_if.rob1_done_i;
                            retire  = 1'b1;
                        end else begin
                            state_nx = HALF;
                        end
                    end
                end
                HALF: begin
                    if (rob_if.rob1_done_i) begin
                        commit1  = 1'b1;
                        retire   = 1'b1;
                        state_nx = RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rob_if.commit0_o = commit0;
    assign rob_if.commit1_o = commit1;
    assign ras_call_o = {commit1 && rob_if.rob1_call_i, commit0 && rob_if.rob0_call_i};
    assign ras_ret_o  = {commit1 && rob_if.rob1_ret_i,  commit0 && rob_if.rob0_ret_i};

    // Pointer, occupancy and FSM state; flush wins over everything and clears on exit.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            state      <= RUN;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            lane1_mask <= '0;
            wait_cnt   <= '0;
        end else if (flush_i) begin
            state    <= FLUSH;
            wait_cnt <= 3'(FLUSH_WAIT);
        end else if (state == FLUSH) begin
            // The first flush-low cycle still counts down, so the blocked window
            // after a one-cycle pulse is FLUSH_WAIT+1 cycles of registered state.
            if (wait_cnt == '0) begin
                state      <= RUN;
                head       <= '0;
                tail       <= '0;
                count      <= '0;
                lane1_mask <= '0;
            end else begin
                wait_cnt <= wait_cnt - 3'd1;
            end
        end else begin
            state <= state_nx;
            if (accept) begin
                lane1_mask[tail] <= rob_if.alloc_lane1_i;
                tail             <= tail + rob_row_t'(1);
            end
            if (retire) begin
                head <= head + rob_row_t'(1);
            end
            case ({accept, retire})
                2'b10:   count <= count + rob_cnt_t'(1);
                2'b01:   count <= count - rob_cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef ROB_COMMIT_PERF_EN
    rob_perf_ctr u_perf_ctr (
        .cpu_clk_i (cpu_clk_i),
        .cpu_rst_i (cpu_rst_i),
        .inc0_i    (commit0),
        .inc1_i    (commit1),
        .count_o   (instret_o)
    );
`else
    assign instret_o = '0;
`endif

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed, table-driven bench for rob_commit_ctrl (FLUSH_WAIT=1).
module tb_rob_commit_ctrl;
    import rob_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  ras_call;
    logic [1:0]  ras_ret;
    logic        empty;
    logic [63:0] instret;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_instret = '0;

    rob_commit_ctrl_if bus ();

    rob_commit_ctrl #(.FLUSH_WAIT(1)) dut (
        .cpu_clk_i  (clk),
        .cpu_rst_i  (rst),
        .flush_i    (flush),
        .rob_if     (bus.slave),
        .ras_call_o (ras_call),
        .ras_ret_o  (ras_ret),
        .empty_o    (empty),
        .instret_o  (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       fl, av, l1, d0, d1;
        logic [1:0] call, ret;
        logic       rdy;
        logic [3:0] row;
        logic [4:0] st0;
        logic [1:0] cm, rc, rr;
        logic       emp;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input string nm, input logic fl, av, l1, d0, d1,
                                input logic [1:0] call, ret, input logic rdy,
                                input logic [3:0] row, input logic [4:0] st0,
                                input logic [1:0] cm, rc, rr, input logic emp);
        vec_t v;
        v.nm = nm; v.fl = fl; v.av = av; v.l1 = l1; v.d0 = d0; v.d1 = d1;
        v.call = call; v.ret = ret; v.rdy = rdy; v.row = row; v.st0 = st0;
        v.cm = cm; v.rc = rc; v.rr = rr; v.emp = emp;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        flush              = v.fl;
        bus.alloc_valid_i  = v.av;
        bus.alloc_lane1_i  = v.l1;
        bus.rob0_done_i    = v.d0;
        bus.rob1_done_i    = v.d1;
        bus.rob0_call_i    = v.call[0];
        bus.rob1_call_i    = v.call[1];
        bus.rob0_ret_i     = v.ret[0];
        bus.rob1_ret_i     = v.ret[1];
        #4;
        chk({v.nm, ".ready"},   64'(bus.alloc_ready_o), 64'(v.rdy));
        chk({v.nm, ".row"},     64'(bus.alloc_row_o),   64'(v.row));
        chk({v.nm, ".status0"}, 64'(bus.rob0_status_o), 64'(v.st0));
        chk({v.nm, ".status1"}, 64'(bus.rob1_status_o), 64'(v.st0 | 5'd1));
        chk({v.nm, ".commit0"}, 64'(bus.commit0_o),     64'(v.cm[0]));
        chk({v.nm, ".commit1"}, 64'(bus.commit1_o),     64'(v.cm[1]));
        chk({v.nm, ".ras_call"}, 64'(ras_call),         64'(v.rc));
        chk({v.nm, ".ras_ret"},  64'(ras_ret),          64'(v.rr));
        chk({v.nm, ".empty"},    64'(empty),            64'(v.emp));
        chk({v.nm, ".instret"},  instret,               exp_instret);
`ifdef ROB_COMMIT_PERF_EN
        exp_instret = exp_instret + 64'(v.cm[0]) + 64'(v.cm[1]);
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.alloc_valid_i = 1'b0; bus.alloc_lane1_i = 1'b0;
        bus.rob0_done_i = 1'b0; bus.rob1_done_i = 1'b0;
        bus.rob0_call_i = 1'b0; bus.rob1_call_i = 1'b0;
        bus.rob0_ret_i = 1'b0;  bus.rob1_ret_i = 1'b0;

        // Test 1: fill all 16 rows, then full
        for (int i = 0; i < 16; i++)
            vq.push_back(mk("t1_alloc", 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 4'(i), 5'd0, 2'b00, 2'b00, 2'b00, i == 0));
        vq.push_back(mk("t1_full", 0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 4'd0, 5'd0, 2'b00, 2'b00, 2'b00, 0));
        // Test 2: row 0 both done in one cycle
        vq.push_back(mk("t2_both",  0, 0, 0, 1, 1, 2'b00, 2'b00, 0, 4'd0, 5'd0, 2'b11, 2'b00, 2'b00, 0));
        vq.push_back(mk("t2_after", 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 4'd0, 5'd2, 2'b00, 2'b00, 2'b00, 0));
        // Test 3: lane 1 done first, lane 0 three cycles later
        for (int i = 0; i < 3; i++)
            vq.push_back(mk("t3_wait", 0, 0, 0, 0, 1, 2'b00, 2'b00, 1, 4'd0, 5'd2, 2'b00, 2'b00, 2'b00, 0));
        vq.push_back(mk("t3_both", 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 4'd0, 5'd2, 2'b11, 2'b00, 2'b00, 0));
        // Test 4: split commit through HALF, lane 1 is a return
        vq.push_back(mk("t4_slot0", 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 4'd0, 5'd4, 2'b01, 2'b00, 2'b00, 0));
        vq.push_back(mk("t4_half",  0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 4'd0, 5'd4, 2'b00, 2'b00, 2'b00, 0));
        vq.push_back(mk("t4_slot1", 0, 0, 0, 0, 1, 2'b00, 2'b10, 1, 4'd0, 5'd4, 2'b10, 2'b00, 2'b10, 0));
        // Drain to the wrap point while allocating a bubble row into row 0
        vq.push_back(mk("drain_alloc", 0, 1, 0, 1, 1, 2'b00, 2'b00, 1, 4'd0, 5'd6, 2'b11, 2'b00, 2'b00, 0));
        for (int h = 4; h < 16; h++)
            vq.push_back(mk("drain", 0, 0, 0, 1, 1, (h == 15) ? 2'b10 : 2'b00, (h == 15) ? 2'b01 : 2'b00,
                            1, 4'd1, 5'(2 * h), 2'b11, (h == 15) ? 2'b10 : 2'b00, (h == 15) ? 2'b01 : 2'b00, 0));
        // Test 5: bubble lane 1 with a call in lane 0
        vq.push_back(mk("t5_bubble", 0, 0, 0, 1, 1, 2'b11, 2'b00, 1, 4'd1, 5'd0, 2'b01, 2'b01, 2'b00, 0));
        // Test 6: five rows, half-commit, flush pulse
        for (int i = 0; i < 5; i++)
            vq.push_back(mk("t6_alloc", 0, 1, 1, i == 0, 0, 2'b00, 2'b00, 1, 4'(i + 1), 5'd2, 2'b00, 2'b00, 2'b00, i == 0));
        vq.push_back(mk("t6_half",  0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 4'd6, 5'd2, 2'b01, 2'b00, 2'b00, 0));
        vq.push_back(mk("t6_flush", 1, 1, 1, 1, 1, 2'b11, 2'b11, 1, 4'd6, 5'd2, 2'b00, 2'b00, 2'b00, 0));
        for (int i = 0; i < 2; i++)
            vq.push_back(mk("t6_wait", 0, 1, 1, 1, 1, 2'b11, 2'b11, 0, 4'd6, 5'd2, 2'b00, 2'b00, 2'b00, 0));
        vq.push_back(mk("t6_done", 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 4'd0, 5'd0, 2'b00, 2'b00, 2'b00, 1));

        #3;
        chk("reset.ready",   64'(bus.alloc_ready_o), 64'd1);
        chk("reset.empty",   64'(empty),             64'd1);
        chk("reset.row",     64'(bus.alloc_row_o),   64'd0);
        chk("reset.commit",  64'({bus.commit1_o, bus.commit0_o}), 64'd0);
        chk("reset.instret", instret,                64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vq[i]) apply(vq[i]);

        // Flush held for three cycles: blocked while held plus the wait window
        apply(mk("fa_assert", 1, 0, 0, 0, 0, 2'b00, 2'b00, 1, 4'd0, 5'd0, 2'b00, 2'b00, 2'b00, 1));
        for (int i = 0; i < 2; i++)
            apply(mk("fa_held", 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 4'd0, 5'd0, 2'b00, 2'b00, 2'b00, 1));
        for (int i = 0; i < 2; i++)
            apply(mk("fa_wait", 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 4'd0, 5'd0, 2'b00, 2'b00, 2'b00, 1));
        apply(mk("fa_exit", 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 4'd0, 5'd0, 2'b00, 2'b00, 2'b00, 1));

        // Full ROB with a same-cycle retire: no allocation until the next cycle
        for (int i = 0; i < 16; i++)
            apply(mk("fb_alloc", 0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 4'(i), 5'd0, 2'b00, 2'b00, 2'b00, i == 0));
        apply(mk("fb_full_retire", 0, 1, 1, 1, 1, 2'b00, 2'b00, 0, 4'd0, 5'd0, 2'b11, 2'b00, 2'b00, 0));
        apply(mk("fb_reopen",      0, 1, 1, 0, 0, 2'b00, 2'b00, 1, 4'd0, 5'd2, 2'b00, 2'b00, 2'b00, 0));
        apply(mk("fb_full_again",  0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 4'd1, 5'd2, 2'b00, 2'b00, 2'b00, 0));

        // Asynchronous reset while full
        bus.alloc_valid_i = 1'b0;
        rst = 1'b1;
        #2;
        chk("areset.ready",   64'(bus.alloc_ready_o), 64'd1);
        chk("areset.empty",   64'(empty),             64'd1);
        chk("areset.row",     64'(bus.alloc_row_o),   64'd0);
        chk("areset.status0", 64'(bus.rob0_status_o), 64'd0);
        chk("areset.instret", instret,                64'd0);
        exp_instret = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply(mk("post_reset", 0, 0, 0, 1, 1, 2'b00, 2'b00, 1, 4'd0, 5'd0, 2'b00, 2'b00, 2'b00, 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
